// File: rtl/trigger_sequencer.sv
// Purpose: arm, detect a falling crossing below trig_level, capture DEPTH samples, drain them over valid/ready.
// Latency: the first sample reaches tx_data DEPTH+1 cycles after the trigger, then one sample per accepted cycle.
// Backpressure: tx_ready low holds tx_data/tx_last; capture never stalls because the record lands in the buffer first.
module trigger_sequencer #(
    parameter int DATA_W  = 14,
    parameter int DEPTH   = 256,
    parameter int HOLDOFF = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] adc_in,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              arm,
    input  logic              auto_rearm,
    input  logic              abort,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last,
    output logic              armed,
    output logic              busy,
    output logic [15:0]       trig_count
);
    localparam int AW   = $clog2(DEPTH);
    localparam int HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);
    localparam logic [HO_W-1:0] HO_LAST  = HO_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_READOUT,
        S_HOLDOFF
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] prev;
    logic              prev_valid;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;
    logic              rd_done;
    logic [HO_W-1:0]   ho_cnt;
    logic              trig;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic              rd_load;
    logic              last_xfer;

    assign trig      = (state == S_ARMED) && prev_valid && (prev >= trig_level) && (adc_in < trig_level);
    assign wr_en     = trig || (state == S_CAPTURE);
    assign wr_addr   = (state == S_CAPTURE) ? wr_idx : '0;
    // The output register doubles as the RAM read register, so a new read is issued whenever it is empty or being drained.
    assign rd_load   = (state == S_READOUT) && !rd_done && (!tx_valid || tx_ready);
    assign last_xfer = tx_valid && tx_ready && tx_last;

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (arm) state_nxt = S_ARMED;
                S_ARMED:   if (trig) state_nxt = S_CAPTURE;
                S_CAPTURE: if (wr_idx == LAST_IDX) state_nxt = S_READOUT;
                S_READOUT: begin
                    if (last_xfer) begin
                        if (HOLDOFF == 0) state_nxt = auto_rearm ? S_ARMED : S_IDLE;
                        else              state_nxt = S_HOLDOFF;
                    end
                end
                S_HOLDOFF: if (ho_cnt == HO_LAST) state_nxt = auto_rearm ? S_ARMED : S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= adc_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            armed      <= 1'b0;
            busy       <= 1'b0;
            prev       <= '0;
            prev_valid <= 1'b0;
            trig_count <= '0;
            wr_idx     <= '0;
            rd_idx     <= '0;
            rd_done    <= 1'b0;
            ho_cnt     <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            tx_last    <= 1'b0;
        end else begin
            state      <= state_nxt;
            armed      <= (state_nxt == S_ARMED);
            busy       <= (state_nxt == S_CAPTURE) || (state_nxt == S_READOUT) || (state_nxt == S_HOLDOFF);
            prev       <= adc_in;
            // Valid only from the second consecutive armed cycle, so every (re-)arm needs a fresh above-level sample.
            prev_valid <= (state == S_ARMED);

            if (trig && !abort) begin
                trig_count <= trig_count + 16'd1;
                wr_idx     <= AW'(1);
                rd_idx     <= '0;
                rd_done    <= 1'b0;
            end else if (state == S_CAPTURE && wr_idx != LAST_IDX) begin
                wr_idx <= wr_idx + AW'(1);
            end

            if (state != S_HOLDOFF)      ho_cnt <= '0;
            else if (ho_cnt != HO_LAST)  ho_cnt <= ho_cnt + HO_W'(1);

            if (abort) begin
                tx_valid <= 1'b0;
                tx_last  <= 1'b0;
            end else if (rd_load) begin
                tx_data  <= mem[rd_idx];
                tx_valid <= 1'b1;
                tx_last  <= (rd_idx == LAST_IDX);
                if (rd_idx == LAST_IDX) rd_done <= 1'b1;
                else                    rd_idx  <= rd_idx + AW'(1);
            end else if (tx_valid && tx_ready) begin
                tx_valid <= 1'b0;
                tx_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer with DEPTH=8, HOLDOFF=4; inputs driven and outputs sampled on the falling edge.
module tb_trigger_sequencer;
    localparam int DATA_W  = 14;
    localparam int DEPTH   = 8;
    localparam int HOLDOFF = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] adc_in;
    logic [DATA_W-1:0] trig_level;
    logic              arm;
    logic              auto_rearm;
    logic              abort;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_last;
    logic              armed;
    logic              busy;
    logic [15:0]       trig_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    trigger_sequencer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .HOLDOFF(HOLDOFF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .adc_in    (adc_in),
        .trig_level(trig_level),
        .arm       (arm),
        .auto_rearm(auto_rearm),
        .abort     (abort),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_last   (tx_last),
        .armed     (armed),
        .busy      (busy),
        .trig_count(trig_count)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; arm = 1'b0; abort = 1'b0; auto_rearm = 1'b0; tx_ready = 1'b0;
        adc_in = 14'd0; trig_level = 14'd8000;
        repeat (2) cyc();
        checks++; if (tx_data !== 14'd0)    begin failures++; $display("FAIL reset_tx_data got=%0d exp=0", tx_data); end
        checks++; if (tx_valid !== 1'b0)    begin failures++; $display("FAIL reset_tx_valid got=%0b exp=0", tx_valid); end
        checks++; if (tx_last !== 1'b0)     begin failures++; $display("FAIL reset_tx_last got=%0b exp=0", tx_last); end
        checks++; if (armed !== 1'b0)       begin failures++; $display("FAIL reset_armed got=%0b exp=0", armed); end
        checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (trig_count !== 16'd0) begin failures++; $display("FAIL reset_trig_count got=%0d exp=0", trig_count); end
        reset = 1'b0;
        cyc();
        checks++; if (armed !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_release_idle armed=%0b busy=%0b exp=0,0", armed, busy); end
    endtask

    task automatic test_basic_ramp();
        logic ev, el, eb;
        trig_level = 14'd8000; auto_rearm = 1'b0; tx_ready = 1'b1;
        cyc(); arm = 1'b1; adc_in = 14'd8200;
        cyc(); arm = 1'b0;
        checks++; if (armed !== 1'b1) begin failures++; $display("FAIL basic_armed got=%0b exp=1", armed); end
        adc_in = 14'd8200;
        cyc(); adc_in = 14'd8100;
        cyc(); adc_in = 14'd8000;
        cyc();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_no_trig_at_level busy=%0b exp=0", busy); end
        adc_in = 14'd7999;
        for (int c = 1; c <= 21; c++) begin
            cyc();
            ev = (c >= 9 && c <= 16); el = (c == 16); eb = (c <= 20);
            checks++; if (tx_valid !== ev) begin failures++; $display("FAIL basic_valid c=%0d got=%0b exp=%0b", c, tx_valid, ev); end
            checks++; if (tx_last !== el)  begin failures++; $display("FAIL basic_last c=%0d got=%0b exp=%0b", c, tx_last, el); end
            checks++; if (busy !== eb)     begin failures++; $display("FAIL basic_busy c=%0d got=%0b exp=%0b", c, busy, eb); end
            checks++; if (armed !== 1'b0)  begin failures++; $display("FAIL basic_armed_low c=%0d got=%0b exp=0", c, armed); end
            if (ev) begin
                checks++; if (tx_data !== 14'(7999 - (c - 9))) begin failures++; $display("FAIL basic_data c=%0d got=%0d exp=%0d", c, tx_data, 7999 - (c - 9)); end
            end
            adc_in = 14'(7999 - c);
        end
        checks++; if (trig_count !== 16'd1) begin failures++; $display("FAIL basic_trig_count got=%0d exp=1", trig_count); end
    endtask

    task automatic test_below_then_stall();
        logic [3:0] pat;
        int p;
        int idx;
        pat = 4'b1001; p = 0; idx = 0; tx_ready = 1'b0;
        cyc(); arm = 1'b1; adc_in = 14'd7000;
        for (int i = 0; i < 8; i++) begin
            cyc(); arm = 1'b0;
            checks++; if (armed !== 1'b1) begin failures++; $display("FAIL below_armed i=%0d got=%0b exp=1", i, armed); end
            adc_in = 14'd7000;
        end
        checks++; if (trig_count !== 16'd1) begin failures++; $display("FAIL below_no_trigger count=%0d exp=1", trig_count); end
        cyc(); adc_in = 14'd8500;
        cyc(); adc_in = 14'd7500;
        for (int c = 1; c <= 60 && idx < 8; c++) begin
            cyc();
            if (c < 9) begin
                checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL stall_early_valid c=%0d got=%0b exp=0", c, tx_valid); end
                tx_ready = 1'b0;
            end else begin
                checks++; if (tx_valid !== 1'b1) begin failures++; $display("FAIL stall_valid c=%0d got=%0b exp=1", c, tx_valid); end
                checks++; if (tx_data !== 14'(7500 - idx)) begin failures++; $display("FAIL stall_data idx=%0d got=%0d exp=%0d", idx, tx_data, 7500 - idx); end
                checks++; if (tx_last !== (idx == 7)) begin failures++; $display("FAIL stall_last idx=%0d got=%0b exp=%0b", idx, tx_last, idx == 7); end
                tx_ready = pat[p % 4];
                p++;
                if (tx_ready) idx++;
            end
            adc_in = 14'(7500 - c);
        end
        checks++; if (idx !== 8) begin failures++; $display("FAIL stall_timeout delivered=%0d exp=8", idx); end
        tx_ready = 1'b1;
        cyc();
        checks++; if (tx_valid !== 1'b0)    begin failures++; $display("FAIL stall_after_valid got=%0b exp=0", tx_valid); end
        checks++; if (busy !== 1'b1)        begin failures++; $display("FAIL stall_holdoff_busy got=%0b exp=1", busy); end
        checks++; if (trig_count !== 16'd2) begin failures++; $display("FAIL stall_trig_count got=%0d exp=2", trig_count); end
        repeat (4) cyc();
        checks++; if (busy !== 1'b0 || armed !== 1'b0) begin failures++; $display("FAIL stall_to_idle busy=%0b armed=%0b exp=0,0", busy, armed); end
    endtask

    task automatic test_auto_rearm();
        logic ev, el, eb, ea;
        int r, ed, ec;
        auto_rearm = 1'b1; tx_ready = 1'b1;
        cyc(); arm = 1'b1; adc_in = 14'd9000;
        cyc(); arm = 1'b0; adc_in = 14'd9000;
        cyc(); adc_in = 14'd7000;
        for (int c = 1; c <= 122; c++) begin
            cyc();
            r  = (c >= 100) ? c - 100 : c;
            ev = (r >= 9 && r <= 16); el = (r == 16);
            eb = (r >= 1 && r <= 20); ea = (r == 0) || (r >= 21);
            ec = (c <= 100) ? 3 : 4;
            ed = (c < 100) ? ((((r - 9) % 2) == 1) ? 9000 : 7000) : 7000 - (r - 9);
            checks++; if (tx_valid !== ev) begin failures++; $display("FAIL auto_valid c=%0d got=%0b exp=%0b", c, tx_valid, ev); end
            checks++; if (tx_last !== el)  begin failures++; $display("FAIL auto_last c=%0d got=%0b exp=%0b", c, tx_last, el); end
            checks++; if (busy !== eb)     begin failures++; $display("FAIL auto_busy c=%0d got=%0b exp=%0b", c, busy, eb); end
            checks++; if (armed !== ea)    begin failures++; $display("FAIL auto_armed c=%0d got=%0b exp=%0b", c, armed, ea); end
            checks++; if (trig_count !== 16'(ec)) begin failures++; $display("FAIL auto_count c=%0d got=%0d exp=%0d", c, trig_count, ec); end
            if (ev) begin
                checks++; if (tx_data !== 14'(ed)) begin failures++; $display("FAIL auto_data c=%0d got=%0d exp=%0d", c, tx_data, ed); end
            end
            if (c <= 19)       adc_in = (c % 2 == 1) ? 14'd9000 : 14'd7000;
            else if (c == 20)  adc_in = 14'd9000;
            else if (c <= 22)  adc_in = 14'd7000;
            else if (c < 100)  adc_in = 14'd9000;
            else               adc_in = 14'(7000 - r);
        end
    endtask

    task automatic test_abort();
        logic ev, el, eb;
        auto_rearm = 1'b0; tx_ready = 1'b1;
        cyc(); adc_in = 14'd9000;
        cyc(); adc_in = 14'd7000;
        cyc();
        checks++; if (busy !== 1'b1 || trig_count !== 16'd5) begin failures++; $display("FAIL abort_pre busy=%0b count=%0d exp=1,5", busy, trig_count); end
        adc_in = 14'd1001;
        cyc(); adc_in = 14'd1002;
        cyc(); abort = 1'b1; adc_in = 14'd1003;
        cyc(); abort = 1'b0;
        checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL abort_busy got=%0b exp=0", busy); end
        checks++; if (armed !== 1'b0)       begin failures++; $display("FAIL abort_armed got=%0b exp=0", armed); end
        checks++; if (trig_count !== 16'd5) begin failures++; $display("FAIL abort_count got=%0d exp=5", trig_count); end
        cyc(); arm = 1'b1; abort = 1'b1;
        cyc(); arm = 1'b0; abort = 1'b0;
        checks++; if (armed !== 1'b0) begin failures++; $display("FAIL abort_over_arm got=%0b exp=0", armed); end
        for (int i = 0; i < 8; i++) begin
            cyc();
            checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abort_quiet i=%0d valid=%0b busy=%0b exp=0,0", i, tx_valid, busy); end
        end
        arm = 1'b1; adc_in = 14'd9000;
        cyc(); arm = 1'b0;
        checks++; if (armed !== 1'b1) begin failures++; $display("FAIL abort_rearm got=%0b exp=1", armed); end
        adc_in = 14'd9000;
        cyc(); adc_in = 14'd9000;
        cyc(); adc_in = 14'd4000;
        for (int d = 1; d <= 21; d++) begin
            cyc();
            ev = (d >= 9 && d <= 16); el = (d == 16); eb = (d <= 20);
            checks++; if (tx_valid !== ev) begin failures++; $display("FAIL fresh_valid d=%0d got=%0b exp=%0b", d, tx_valid, ev); end
            checks++; if (tx_last !== el)  begin failures++; $display("FAIL fresh_last d=%0d got=%0b exp=%0b", d, tx_last, el); end
            checks++; if (busy !== eb)     begin failures++; $display("FAIL fresh_busy d=%0d got=%0b exp=%0b", d, busy, eb); end
            if (ev) begin
                checks++; if (tx_data !== 14'(4000 + 3 * (d - 9))) begin failures++; $display("FAIL fresh_data d=%0d got=%0d exp=%0d", d, tx_data, 4000 + 3 * (d - 9)); end
            end
            adc_in = 14'(4000 + 3 * d);
        end
        checks++; if (trig_count !== 16'd6) begin failures++; $display("FAIL fresh_count got=%0d exp=6", trig_count); end
    endtask

    task automatic test_reset_mid_readout();
        tx_ready = 1'b1;
        cyc(); arm = 1'b1; adc_in = 14'd9000;
        cyc(); arm = 1'b0;
        cyc(); adc_in = 14'd7000;
        for (int c = 1; c <= 16; c++) begin
            cyc(); adc_in = 14'(7000 - c);
        end
        checks++; if (tx_valid !== 1'b1 || tx_last !== 1'b1) begin failures++; $display("FAIL rst_pre valid=%0b last=%0b exp=1,1", tx_valid, tx_last); end
        checks++; if (trig_count !== 16'd7) begin failures++; $display("FAIL rst_pre_count got=%0d exp=7", trig_count); end
        #2 reset = 1'b1;
        #1;
        checks++; if (tx_valid !== 1'b0)    begin failures++; $display("FAIL rst_async_valid got=%0b exp=0", tx_valid); end
        checks++; if (tx_last !== 1'b0)     begin failures++; $display("FAIL rst_async_last got=%0b exp=0", tx_last); end
        checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL rst_async_busy got=%0b exp=0", busy); end
        checks++; if (trig_count !== 16'd0) begin failures++; $display("FAIL rst_async_count got=%0d exp=0", trig_count); end
        cyc(); cyc(); reset = 1'b0;
        cyc();
        checks++; if (armed !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0) begin failures++; $display("FAIL rst_release armed=%0b busy=%0b valid=%0b exp=0,0,0", armed, busy, tx_valid); end
        arm = 1'b1;
        cyc(); arm = 1'b0;
        checks++; if (armed !== 1'b1) begin failures++; $display("FAIL rst_idle_arm got=%0b exp=1", armed); end
    endtask

    initial begin
        test_reset();
        test_basic_ramp();
        test_below_then_stall();
        test_auto_rearm();
        test_abort();
        test_reset_mid_readout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
